// File: rtl/lead_one_pkg.sv
// Shared helpers for the leading-one normaliser.
// Widths, bit reversal and group counting.
package lead_one_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ngroups(input int w, input int g);
    return (w + g - 1) / g;
  endfunction

  // Reverses the low w bits of x; upper bits come back zero.
  function automatic logic [63:0] bitrev(
    input logic [63:0] x,
    input int          w
  );
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (i < w) r[i] = x[w-1-i];
    return r;
  endfunction

endpackage

// File: rtl/lo_group_enc.sv
// MSB-first leading-zero encoder for one group.
// nz flags any set bit; lzc counts zeros above the first one.
module lo_group_enc
  import lead_one_pkg::*;
#(
  parameter  int GROUP = 8,
  localparam int LW    = (GROUP > 1) ? clog2(GROUP) : 1
) (
  input  logic [GROUP-1:0] d,
  output logic             nz,
  output logic [LW-1:0]    lzc
);

  logic found;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = GROUP - 1; i >= 0; i--) begin
      if (!found && d[i]) begin
        lzc   = LW'(GROUP - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign nz = |d;

endmodule

// File: rtl/lead_one_norm.sv
// Two-stage leading-one detector and normaliser.
// Both search modes share one MSB-first datapath.
module lead_one_norm
  import lead_one_pkg::*;
#(
  parameter  int WIDTH = 25,
  parameter  int GROUP = 8,
  localparam int CNT_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_pos,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_lsb_first
);

  localparam int NG = ngroups(WIDTH, GROUP);
  localparam int PW = NG * GROUP;
  localparam int LW = (GROUP > 1) ? clog2(GROUP) : 1;

  logic s1_load;
  logic s2_load;

  logic [WIDTH-1:0]        orient;
  logic [PW-1:0]           pad;
  logic [NG-1:0]           g_nz;
  logic [NG-1:0][LW-1:0]   g_lzc;

  logic                    s1_valid;
  logic [NG-1:0]           s1_nz;
  logic [NG-1:0][LW-1:0]   s1_lzc;
  logic [WIDTH-1:0]        s1_word;
  logic                    s1_lsb;

  logic [CNT_W-1:0]        pos_c;
  logic                    zero_c;
  logic [WIDTH-1:0]        shl_c;
  logic [WIDTH-1:0]        norm_c;

  assign s2_load  = ~out_valid | out_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign in_ready = s1_load;

  assign orient = in_lsb_first
                ? WIDTH'(bitrev(64'(in_data), WIDTH))
                : in_data;

  // Padding sits below the word so it is never reached first.
  always_comb begin
    pad = '0;
    pad[PW-1 -: WIDTH] = orient;
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    lo_group_enc #(
      .GROUP (GROUP)
    ) u_enc (
      .d   (pad[PW-1-g*GROUP -: GROUP]),
      .nz  (g_nz[g]),
      .lzc (g_lzc[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_nz    <= '0;
      s1_lzc   <= '0;
      s1_word  <= '0;
      s1_lsb   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_nz   <= g_nz;
        s1_lzc  <= g_lzc;
        s1_word <= orient;
        s1_lsb  <= in_lsb_first;
      end
    end
  end

  // Lowest-index nonzero group wins, so scan downward.
  always_comb begin
    pos_c = '0;
    for (int g = NG - 1; g >= 0; g--)
      if (s1_nz[g])
        pos_c = CNT_W'(g * GROUP + int'(s1_lzc[g]));
  end

  assign zero_c = ~|s1_nz;
  assign shl_c  = s1_word << pos_c;
  assign norm_c = s1_lsb
                ? WIDTH'(bitrev(64'(shl_c), WIDTH))
                : shl_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pos       <= '0;
      out_zero      <= 1'b0;
      out_norm      <= '0;
      out_lsb_first <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pos       <= pos_c;
        out_zero      <= zero_c;
        out_norm      <= norm_c;
        out_lsb_first <= s1_lsb;
      end
    end
  end

endmodule

// File: tb/tb_lead_one_norm.sv
// Testbench for lead_one_norm: vector table, streaming
// scoreboard, reset flush and one-hot sweeps.
module tb_lead_one_norm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance 25/8
  logic        m_in_valid = 0, m_in_ready, m_in_lsb = 0;
  logic [24:0] m_in_data = '0;
  logic        m_out_valid, m_out_ready = 1, m_out_zero, m_out_lsb;
  logic [4:0]  m_out_pos;
  logic [24:0] m_out_norm;

  // 32/4 instance
  logic        a_in_valid = 0, a_in_ready, a_in_lsb = 0;
  logic [31:0] a_in_data = '0;
  logic        a_out_valid, a_out_zero, a_out_lsb;
  logic [4:0]  a_out_pos;
  logic [31:0] a_out_norm;

  // 13/8 instance (padded last group)
  logic        b_in_valid = 0, b_in_ready, b_in_lsb = 0;
  logic [12:0] b_in_data = '0;
  logic        b_out_valid, b_out_zero, b_out_lsb;
  logic [3:0]  b_out_pos;
  logic [12:0] b_out_norm;

  lead_one_norm #(.WIDTH(25), .GROUP(8)) u_m (
    .clk(clk), .rst(rst),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_data(m_in_data), .in_lsb_first(m_in_lsb),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_pos(m_out_pos), .out_zero(m_out_zero),
    .out_norm(m_out_norm), .out_lsb_first(m_out_lsb)
  );

  lead_one_norm #(.WIDTH(32), .GROUP(4)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_lsb_first(a_in_lsb),
    .out_valid(a_out_valid), .out_ready(1'b1),
    .out_pos(a_out_pos), .out_zero(a_out_zero),
    .out_norm(a_out_norm), .out_lsb_first(a_out_lsb)
  );

  lead_one_norm #(.WIDTH(13), .GROUP(8)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_lsb_first(b_in_lsb),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .out_pos(b_out_pos), .out_zero(b_out_zero),
    .out_norm(b_out_norm), .out_lsb_first(b_out_lsb)
  );

  typedef struct {
    logic [24:0] d;
    logic        lsb;
    int          pos;
    logic        zero;
    logic [24:0] norm;
  } vec_t;

  typedef struct {
    int          pos;
    logic        zero;
    logic [63:0] norm;
    logic        lsb;
  } exp_t;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Reference: locate the first one with a plain scan, then shift.
  function automatic exp_t model(input logic [63:0] d, input logic lsb,
                                 input int w);
    exp_t e;
    logic [63:0] mask;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    e.zero = ((d & mask) == 0);
    e.pos  = 0;
    e.norm = '0;
    e.lsb  = lsb;
    if (!e.zero) begin
      if (!lsb) begin
        for (int i = 0; i < w; i++) if (d[i]) e.pos = w - 1 - i;
        e.norm = (d << e.pos) & mask;
      end else begin
        for (int i = w - 1; i >= 0; i--) if (d[i]) e.pos = i;
        e.norm = (d & mask) >> e.pos;
      end
    end
    return e;
  endfunction

  task automatic check_m(input string n, input exp_t e);
    chk({n, " valid"}, 64'(m_out_valid), 64'd1);
    chk({n, " pos"},   64'(m_out_pos),   64'(e.pos));
    chk({n, " zero"},  64'(m_out_zero),  64'(e.zero));
    chk({n, " norm"},  64'(m_out_norm),  e.norm);
    chk({n, " mode"},  64'(m_out_lsb),   64'(e.lsb));
  endtask

  // One isolated word on the main instance, checking the 2-cycle latency.
  task automatic send_one(input string n, input logic [24:0] d,
                          input logic lsb, input exp_t e);
    @(negedge clk);
    m_out_ready = 1;
    m_in_valid  = 1;
    m_in_data   = d;
    m_in_lsb    = lsb;
    #1;
    chk({n, " in_ready"}, 64'(m_in_ready), 64'd1);
    @(negedge clk);
    m_in_valid = 0;
    chk({n, " early"}, 64'(m_out_valid), 64'd0);
    @(negedge clk);
    check_m(n, e);
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{25'h1000000, 0, 0,  0, 25'h1000000};
    vt[1] = '{25'h0000001, 0, 24, 0, 25'h1000000};
    vt[2] = '{25'h0000300, 0, 15, 0, 25'h1800000};
    vt[3] = '{25'h0000100, 1, 8,  0, 25'h0000001};
    vt[4] = '{25'h0000000, 0, 0,  1, 25'h0000000};
    vt[5] = '{25'h0000000, 1, 0,  1, 25'h0000000};
    vt[6] = '{25'h1000000, 1, 24, 0, 25'h0000001};
    vt[7] = '{25'h1FFFFFF, 0, 0,  0, 25'h1FFFFFF};
    vt[8] = '{25'h0000006, 1, 1,  0, 25'h0000003};
    vt[9] = '{25'h00000FF, 0, 17, 0, 25'h1FE0000};

    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset out_valid", 64'(m_out_valid), 64'd0);
    chk("reset out_pos",   64'(m_out_pos),   64'd0);
    chk("reset out_norm",  64'(m_out_norm),  64'd0);
    chk("reset in_ready",  64'(m_in_ready),  64'd1);

    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e = '{vt[i].pos, vt[i].zero, 64'(vt[i].norm), vt[i].lsb};
      send_one($sformatf("vec%0d", i), vt[i].d, vt[i].lsb, e);
    end

    // Streaming with random backpressure and alternating mode.
    begin
      exp_t q[$];
      exp_t e;
      int sent = 0, got = 0, cyc = 0;
      logic mode = 0, hold = 0, stalled = 0;
      logic [4:0]  sv_pos;
      logic        sv_zero, sv_lsb;
      logic [24:0] sv_norm;
      while ((sent < 100 || got < 100) && cyc < 3000) begin
        @(negedge clk);
        cyc++;
        if (stalled) begin
          chk("stall valid", 64'(m_out_valid), 64'd1);
          chk("stall pos",   64'(m_out_pos),   64'(sv_pos));
          chk("stall zero",  64'(m_out_zero),  64'(sv_zero));
          chk("stall norm",  64'(m_out_norm),  64'(sv_norm));
          chk("stall mode",  64'(m_out_lsb),   64'(sv_lsb));
        end
        if (!hold) begin
          if (sent < 100 && $urandom_range(0, 3) != 0) begin
            m_in_valid = 1;
            m_in_lsb   = mode;
            if ($urandom_range(0, 15) == 0) m_in_data = '0;
            else m_in_data = 25'($urandom) >> $urandom_range(0, 24);
          end else begin
            m_in_valid = 0;
          end
        end
        m_out_ready = 1'($urandom_range(0, 1));
        #1;
        if (m_out_valid && m_out_ready) begin
          if (q.size() == 0) begin
            chk("stream extra", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check_m($sformatf("stream%0d", got), e);
          end
          got++;
        end
        if (m_in_valid && m_in_ready) begin
          q.push_back(model(64'(m_in_data), m_in_lsb, 25));
          sent++;
          mode = ~mode;
          hold = 0;
        end else begin
          hold = m_in_valid;
        end
        stalled = m_out_valid && !m_out_ready;
        sv_pos  = m_out_pos;
        sv_zero = m_out_zero;
        sv_norm = m_out_norm;
        sv_lsb  = m_out_lsb;
      end
      chk("stream timeout", 64'(cyc >= 3000), 64'd0);
      chk("stream leftover", 64'(q.size()), 64'd0);
    end

    // Fill the pipeline under backpressure, then reset mid-stream.
    @(negedge clk);
    m_in_valid  = 0;
    m_out_ready = 0;
    repeat (4) begin
      @(negedge clk);
      m_in_valid = 1;
      m_in_lsb   = 0;
      m_in_data  = 25'h0000F00;
    end
    @(negedge clk);
    m_in_valid = 0;
    chk("full out_valid", 64'(m_out_valid), 64'd1);
    chk("full in_ready",  64'(m_in_ready),  64'd0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst out_valid", 64'(m_out_valid), 64'd0);
    chk("rst out_pos",   64'(m_out_pos),   64'd0);
    chk("rst out_zero",  64'(m_out_zero),  64'd0);
    chk("rst out_norm",  64'(m_out_norm),  64'd0);
    chk("rst out_mode",  64'(m_out_lsb),   64'd0);
    chk("rst in_ready",  64'(m_in_ready),  64'd1);
    @(negedge clk);
    chk("rst no ghost", 64'(m_out_valid), 64'd0);
    send_one("post_rst", 25'h0040000, 1'b1, model(64'h40000, 1'b1, 25));
    send_one("post_rst2", 25'h0040000, 1'b0, model(64'h40000, 1'b0, 25));

    // One-hot sweep on the 32/4 and 13/8 instances.
    for (int b = 0; b < 32; b++) begin
      for (int md = 0; md < 2; md++) begin
        exp_t ea, eb;
        logic [63:0] one;
        one = 64'd1 << b;
        @(negedge clk);
        a_in_valid = 1;
        a_in_data  = 32'(one);
        a_in_lsb   = 1'(md);
        b_in_valid = (b < 13);
        b_in_data  = 13'(one);
        b_in_lsb   = 1'(md);
        @(negedge clk);
        a_in_valid = 0;
        b_in_valid = 0;
        @(negedge clk);
        ea = model(one, 1'(md), 32);
        chk($sformatf("w32 b%0d m%0d valid", b, md), 64'(a_out_valid), 64'd1);
        chk($sformatf("w32 b%0d m%0d pos", b, md), 64'(a_out_pos), 64'(ea.pos));
        chk($sformatf("w32 b%0d m%0d norm", b, md), 64'(a_out_norm), ea.norm);
        if (b < 13) begin
          eb = model(one, 1'(md), 13);
          chk($sformatf("w13 b%0d m%0d valid", b, md), 64'(b_out_valid), 64'd1);
          chk($sformatf("w13 b%0d m%0d pos", b, md), 64'(b_out_pos), 64'(eb.pos));
          chk($sformatf("w13 b%0d m%0d zero", b, md), 64'(b_out_zero), 64'd0);
          chk($sformatf("w13 b%0d m%0d norm", b, md), 64'(b_out_norm), eb.norm);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
